// File: rtl/i2c_codec_target_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the WM8731-style I2C write-only target:
//   - FSM state encoding
//   - WM8731 bus address and register-index constants
//   - register-file geometry and a saturating counter helper
// ---------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_BYTE1    = 3'd3,
    ST_ACK1     = 3'd4,
    ST_BYTE2    = 3'd5,
    ST_ACK2     = 3'd6,
    ST_IGNORE   = 3'd7
  } i2c_state_e;

  localparam logic [6:0] WM8731_ADDR = 7'h1A;

  localparam logic [6:0] REG_LHP   = 7'h02;
  localparam logic [6:0] REG_RHP   = 7'h03;
  localparam logic [6:0] REG_APATH = 7'h04;
  localparam logic [6:0] REG_DPATH = 7'h05;
  localparam logic [6:0] REG_PWR   = 7'h06;
  localparam logic [6:0] REG_FMT   = 7'h07;
  localparam logic [6:0] REG_SMP   = 7'h08;
  localparam logic [6:0] REG_ACT   = 7'h09;
  localparam logic [6:0] REG_RESET = 7'h0F;

  localparam int RD_ADDR_W = 4;
  localparam int REG_W     = 9;

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

endpackage

// File: rtl/i2c_codec_target_if.sv
// ---------------------------------------------------------------------------
// i2c_codec_target_if
// Host-side view of the codec target: register-file read port, write
// command monitor and status.
//   rd_addr  : register-file read index        (host -> target)
//   rd_data  : value of register rd_addr       (target -> host)
//   wr_valid : one-clk pulse per completed command
//   wr_addr  : register address of the last command
//   wr_data  : 9-bit data of the last command
//   busy     : high between START and STOP
//   active   : bit 0 of the ACTIVE register
//   err_cnt  : saturating count of NACKed address bytes
// modport slave  : used by the target
// modport master : used by whoever observes/reads the target
// ---------------------------------------------------------------------------
interface i2c_codec_target_if;
  import i2c_pkg::*;

  logic [RD_ADDR_W-1:0] rd_addr;
  logic [REG_W-1:0]     rd_data;
  logic                 wr_valid;
  logic [6:0]           wr_addr;
  logic [REG_W-1:0]     wr_data;
  logic                 busy;
  logic                 active;
  logic [7:0]           err_cnt;

  modport slave (
    input  rd_addr,
    output rd_data, wr_valid, wr_addr, wr_data, busy, active, err_cnt
  );

  modport master (
    output rd_addr,
    input  rd_data, wr_valid, wr_addr, wr_data, busy, active, err_cnt
  );

endinterface

// File: rtl/i2c_codec_target_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync
// Brings SCL/SDA into the clk domain and derives bus events.
// Each line goes through a 2-FF synchronizer plus one more stage used only
// for edge detection, so all events refer to synchronized values.
//   clk, rst        : system clock, synchronous active-high reset
//   scl_i, sda_i    : raw bus lines
//   scl_rise_o      : synchronized SCL rising edge (one clk)
//   scl_fall_o      : synchronized SCL falling edge (one clk)
//   start_det_o     : SDA fell while SCL stayed high
//   stop_det_o      : SDA rose while SCL stayed high
//   sda_s_o         : synchronized SDA level
// ---------------------------------------------------------------------------
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic sda_s_o
);

  // Index 0 is the first synchronizer stage, 1 the synchronized value,
  // 2 the previous synchronized value.
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  // Synchronizer and edge-history shift registers; reset to the idle bus
  // level (both high) so leaving reset cannot fake a START.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign scl_rise_o  =  scl_q[1] & ~scl_q[2];
  assign scl_fall_o  = ~scl_q[1] &  scl_q[2];
  // SCL must be high in both samples so an SDA change near an SCL edge
  // is not mistaken for a bus condition.
  assign start_det_o =  scl_q[1] &  scl_q[2] &  sda_q[2] & ~sda_q[1];
  assign stop_det_o  =  scl_q[1] &  scl_q[2] & ~sda_q[2] &  sda_q[1];
  assign sda_s_o     =  sda_q[1];

endmodule

// File: rtl/i2c_codec_target.sv
// ---------------------------------------------------------------------------
// i2c_codec_target
// Write-only I2C target modelling the WM8731 control port. Accepts frames
// {dev_addr,W} {reg[6:0],data[8]} {data[7:0]} (several commands may follow
// one address byte) and keeps the 9-bit register values.
//   clk, rst  : 50 MHz clock, synchronous active-high reset
//   i2c_sclk  : bus clock from the master
//   i2c_sdat  : bus data; only ever pulled low by this block, else high-Z
//   host      : register read port, command monitor and status
// ---------------------------------------------------------------------------
module i2c_codec_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = WM8731_ADDR,
  parameter int         NUM_REGS  = 10,
  parameter logic [6:0] RESET_REG = REG_RESET
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i2c_sclk,
  inout  wire                 i2c_sdat,
  i2c_codec_target_if.slave   host
);

  logic scl_rise_s, scl_fall_s, start_det_s, stop_det_s, sda_s;

  i2c_bus_sync u_bus_sync (
    .clk         (clk),
    .rst         (rst),
    .scl_i       (i2c_sclk),
    .sda_i       (i2c_sdat),
    .scl_rise_o  (scl_rise_s),
    .scl_fall_o  (scl_fall_s),
    .start_det_o (start_det_s),
    .stop_det_o  (stop_det_s),
    .sda_s_o     (sda_s)
  );

  i2c_state_e       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             ack_drive_q, ack_drive_d;
  // Set once SDA is pulled low for an ACK; the next SCL fall then releases.
  logic             ack_hold_q, ack_hold_d;
  logic             data8_q, data8_d;
  logic             busy_q, busy_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             wr_valid_q, wr_valid_d;
  logic [6:0]       wr_addr_q, wr_addr_d;
  logic [REG_W-1:0] wr_data_q, wr_data_d;
  logic [REG_W-1:0] regs_q [NUM_REGS];
  logic [REG_W-1:0] regs_d [NUM_REGS];
  logic [7:0]       byte_s;
  logic [REG_W-1:0] rd_data_s;
  logic             active_s;

  assign i2c_sdat = ack_drive_q ? 1'b0 : 1'bz;

  // State, datapath and register file; reset clears everything and
  // releases SDA on the very next clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      ack_drive_q <= 1'b0;
      ack_hold_q  <= 1'b0;
      data8_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_cnt_q   <= 8'd0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= 7'd0;
      wr_data_q   <= 9'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 9'd0;
      end
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ack_drive_q <= ack_drive_d;
      ack_hold_q  <= ack_hold_d;
      data8_q     <= data8_d;
      busy_q      <= busy_d;
      err_cnt_q   <= err_cnt_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Next-state logic: bus conditions first, then per-state bit handling.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ack_drive_d = ack_drive_q;
    ack_hold_d  = ack_hold_q;
    data8_d     = data8_q;
    busy_d      = busy_q;
    err_cnt_d   = err_cnt_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    regs_d      = regs_q;
    // Byte value including the bit being sampled this clk.
    byte_s      = {shift_q[6:0], sda_s};

    // START/STOP abort whatever is in progress, including an 8th bit
    // sampled in the same clk.
    if (stop_det_s) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 3'd0;
      ack_drive_d = 1'b0;
      ack_hold_d  = 1'b0;
      busy_d      = 1'b0;
    end else if (start_det_s) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = 3'd0;
      ack_drive_d = 1'b0;
      ack_hold_d  = 1'b0;
      busy_d      = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise_s) begin
            shift_d   = byte_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if ((byte_s[7:1] == DEV_ADDR) && (byte_s[0] == 1'b0)) begin
                state_d = ST_ADDR_ACK;
              end else begin
                state_d   = ST_IGNORE;
                err_cnt_d = sat_inc8(err_cnt_q);
              end
            end else begin
              state_d = ST_ADDR;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_BYTE1: begin
          if (scl_rise_s) begin
            shift_d   = byte_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              wr_addr_d = byte_s[7:1];
              data8_d   = byte_s[0];
              state_d   = ST_ACK1;
            end else begin
              state_d = ST_BYTE1;
            end
          end else begin
            state_d = ST_BYTE1;
          end
        end
        ST_BYTE2: begin
          if (scl_rise_s) begin
            shift_d   = byte_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              wr_data_d = {data8_q, byte_s};
              state_d   = ST_ACK2;
            end else begin
              state_d = ST_BYTE2;
            end
          end else begin
            state_d = ST_BYTE2;
          end
        end
        ST_ADDR_ACK, ST_ACK1, ST_ACK2: begin
          if (scl_fall_s) begin
            if (!ack_hold_q) begin
              // Fall that ends the 8th bit: start driving the ACK.
              ack_drive_d = 1'b1;
              ack_hold_d  = 1'b1;
              if (state_q == ST_ACK2) begin
                wr_valid_d = 1'b1;
                if (wr_addr_q == RESET_REG) begin
                  for (int i = 0; i < NUM_REGS; i++) begin
                    regs_d[i] = 9'd0;
                  end
                end else begin
                  // Addresses beyond the file match no entry and store nothing.
                  for (int i = 0; i < NUM_REGS; i++) begin
                    regs_d[i] = (wr_addr_q == 7'(i)) ? wr_data_q : regs_q[i];
                  end
                end
              end else begin
                wr_valid_d = 1'b0;
              end
            end else begin
              // Fall that ends the ACK clock: release and go to next byte.
              ack_drive_d = 1'b0;
              ack_hold_d  = 1'b0;
              bit_cnt_d   = 3'd0;
              state_d     = (state_q == ST_ACK1) ? ST_BYTE2 : ST_BYTE1;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_IDLE, ST_IGNORE: begin
          ack_drive_d = 1'b0;
          ack_hold_d  = 1'b0;
        end
        default: begin
          state_d     = ST_IDLE;
          ack_drive_d = 1'b0;
          ack_hold_d  = 1'b0;
          busy_d      = 1'b0;
        end
      endcase
    end
  end

  // Read mux and ACTIVE bit; indices outside the file read as zero.
  always_comb begin
    rd_data_s = 9'd0;
    active_s  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_data_s = rd_data_s | ({REG_W{host.rd_addr == 4'(i)}} & regs_q[i]);
      active_s  = active_s | ((REG_ACT == 7'(i)) & regs_q[i][0]);
    end
  end

  assign host.rd_data  = rd_data_s;
  assign host.active   = active_s;
  assign host.wr_valid = wr_valid_q;
  assign host.wr_addr  = wr_addr_q;
  assign host.wr_data  = wr_data_q;
  assign host.busy     = busy_q;
  assign host.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_i2c_codec_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_codec_target
// Directed bench: a bit-level I2C master drives write frames; expected
// commands go into a scoreboard queue and are matched on every wr_valid.
// ---------------------------------------------------------------------------
module tb_i2c_codec_target;

  localparam int P = 8;  // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_oe = 1'b0;   // 1 = master pulls SDA low
  wire  sda;

  assign sda = sda_oe ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_codec_target_if host_if ();

  i2c_codec_target dut (
    .clk      (clk),
    .rst      (rst),
    .i2c_sclk (scl_m),
    .i2c_sdat (sda),
    .host     (host_if)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int wr_seen = 0;
  logic [15:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every wr_valid pops the oldest expected {addr,data}.
  always @(negedge clk) begin
    logic [15:0] exp_w;
    if (host_if.wr_valid === 1'b1) begin
      wr_seen++;
      exp_w = (sb_q.size() != 0) ? sb_q.pop_front() : 16'hxxxx;
      check("wr_cmd", {host_if.wr_addr, host_if.wr_data}, exp_w);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic bus_start();
    sda_oe = 1'b0; wait_clk(P);
    scl_m = 1'b1;  wait_clk(P);
    sda_oe = 1'b1; wait_clk(P);
    scl_m = 1'b0;  wait_clk(P);
  endtask

  task automatic bus_stop();
    sda_oe = 1'b1; wait_clk(P);
    scl_m = 1'b1;  wait_clk(P);
    sda_oe = 1'b0; wait_clk(P);
  endtask

  task automatic send_bit(input logic b);
    sda_oe = ~b;  wait_clk(P);
    scl_m = 1'b1; wait_clk(2 * P);
    scl_m = 1'b0; wait_clk(P);
  endtask

  // Master releases SDA for the 9th clock and samples it mid-high.
  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic smp;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_oe = 1'b0; wait_clk(P);
    scl_m = 1'b1;  wait_clk(P);
    @(negedge clk); smp = sda;
    wait_clk(P);
    scl_m = 1'b0;  wait_clk(P);
    check(tag, {31'd0, smp}, {31'd0, ~exp_ack});
  endtask

  task automatic rd_check(input logic [3:0] a, input logic [8:0] exp, input string tag);
    host_if.rd_addr = a;
    @(negedge clk);
    check(tag, {23'd0, host_if.rd_data}, {23'd0, exp});
  endtask

  initial begin
    host_if.rd_addr = 4'd0;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(2);
    @(negedge clk);
    check("rst_busy", host_if.busy, 1'b0);
    check("rst_errcnt", host_if.err_cnt, 8'd0);
    check("rst_wrcmd", {host_if.wr_valid, host_if.wr_addr, host_if.wr_data}, 17'd0);
    check("rst_active", host_if.active, 1'b0);
    check("rst_sda", sda, 1'b1);
    rd_check(4'd6, 9'd0, "rst_rd6");

    // Single command 0x06 <- 0x010
    bus_start();
    @(negedge clk); check("busy_start", host_if.busy, 1'b1);
    send_byte(8'h34, 1'b1, "ack_addr");
    send_byte(8'h0C, 1'b1, "ack_b1");
    sb_q.push_back({7'h06, 9'h010});
    send_byte(8'h10, 1'b1, "ack_b2");
    bus_stop();
    check("wr_cnt1", wr_seen, 1);
    check("last_cmd", {host_if.wr_addr, host_if.wr_data}, {7'h06, 9'h010});
    rd_check(4'd6, 9'h010, "rd6");
    check("busy_stop", host_if.busy, 1'b0);

    // Wrong address: NACK, ignore the rest
    bus_start();
    send_byte(8'h36, 1'b0, "nack_addr1b");
    send_byte(8'h0C, 1'b0, "nack_ign_b1");
    send_byte(8'h55, 1'b0, "nack_ign_b2");
    bus_stop();
    check("errcnt1", host_if.err_cnt, 8'd1);

    // Right address, read direction: NACK
    bus_start();
    send_byte(8'h35, 1'b0, "nack_read");
    send_byte(8'h0C, 1'b0, "nack_rd_b1");
    send_byte(8'h77, 1'b0, "nack_rd_b2");
    bus_stop();
    check("errcnt2", host_if.err_cnt, 8'd2);
    rd_check(4'd6, 9'h010, "rd6_unchanged");
    check("wr_cnt_nack", wr_seen, 1);

    // Two commands in one transaction
    bus_start();
    send_byte(8'h34, 1'b1, "ack_addr2");
    send_byte(8'h12, 1'b1, "ack_act_b1");
    sb_q.push_back({7'h09, 9'h001});
    send_byte(8'h01, 1'b1, "ack_act_b2");
    send_byte(8'h0E, 1'b1, "ack_fmt_b1");
    sb_q.push_back({7'h07, 9'h002});
    send_byte(8'h02, 1'b1, "ack_fmt_b2");
    @(negedge clk); check("busy_before_stop", host_if.busy, 1'b1);
    bus_stop();
    check("wr_cnt3", wr_seen, 3);
    check("active1", host_if.active, 1'b1);
    rd_check(4'd7, 9'h002, "rd7");
    check("busy_after_stop", host_if.busy, 1'b0);

    // Load LHP/RHP with data[8]=0 and data[8]=1, then reset register
    bus_start();
    send_byte(8'h34, 1'b1, "ack_addr3");
    send_byte(8'h04, 1'b1, "ack_lhp_b1");
    sb_q.push_back({7'h02, 9'h079});
    send_byte(8'h79, 1'b1, "ack_lhp_b2");
    send_byte(8'h07, 1'b1, "ack_rhp_b1");
    sb_q.push_back({7'h03, 9'h179});
    send_byte(8'h79, 1'b1, "ack_rhp_b2");
    bus_stop();
    rd_check(4'd2, 9'h079, "rd2");
    rd_check(4'd3, 9'h179, "rd3");
    bus_start();
    send_byte(8'h34, 1'b1, "ack_addr4");
    send_byte(8'h1E, 1'b1, "ack_rst_b1");
    sb_q.push_back({7'h0F, 9'h000});
    send_byte(8'h00, 1'b1, "ack_rst_b2");
    bus_stop();
    for (int i = 0; i < 10; i++) rd_check(4'(i), 9'd0, "rd_cleared");
    check("active0", host_if.active, 1'b0);
    rd_check(4'd12, 9'd0, "rd_out_of_range");

    // STOP after 4 bits of BYTE2 discards the command
    bus_start();
    send_byte(8'h34, 1'b1, "ack_addr5");
    send_byte(8'h0A, 1'b1, "ack_dp_b1");
    sb_q.push_back({7'h05, 9'h0AB});
    send_byte(8'hAB, 1'b1, "ack_dp_b2");
    send_byte(8'h0A, 1'b1, "ack_part_b1");
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus_stop();
    check("wr_cnt_partial", wr_seen, 7);
    rd_check(4'd5, 9'h0AB, "rd5_unchanged");
    check("sda_partial", sda, 1'b1);
    check("busy_partial", host_if.busy, 1'b0);

    // Reset while the address ACK is being driven
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 1 ? 1'b0 : ((8'h34 >> i) & 8'h01) != 8'h00);
    sda_oe = 1'b0;
    @(negedge clk); check("ack_drive_low", sda, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_sda_release", sda, 1'b1);
    check("rst_busy2", host_if.busy, 1'b0);
    check("rst_errcnt2", host_if.err_cnt, 8'd0);
    check("rst_wrcmd2", {host_if.wr_valid, host_if.wr_addr, host_if.wr_data}, 17'd0);
    rd_check(4'd5, 9'd0, "rst_rd5");
    rst = 1'b0;
    scl_m = 1'b1;
    wait_clk(2 * P);

    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
